// File: rtl/packet_output_scheduler.sv
// Output-port scheduler: arbitrates head flits, locks the winner until its tail,
// muxes flits onto the output link and tracks downstream buffer credits.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   requests_i/head_i/tail_i      per-agent buffer-head status
//   flits_i                       per-agent head flit, agent i at [i*FLIT_SIZE +: FLIT_SIZE]
//   arb_requests_o/arb_grants_i   request/grant pair to an external round-robin arbiter
//   pop_o                         one-hot consume strobe back to the input buffers
//   valid_o/flit_o                registered output link
//   credit_i/credit_error_o       downstream credit return, overflow pulse
module packet_output_scheduler #(
  parameter int AGENTS_NUM = 4,
  parameter int FLIT_SIZE  = 16,
  parameter int CREDIT_MAX = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AGENTS_NUM-1:0]            requests_i,
  input  logic [AGENTS_NUM-1:0]            head_i,
  input  logic [AGENTS_NUM-1:0]            tail_i,
  input  logic [AGENTS_NUM*FLIT_SIZE-1:0]  flits_i,
  output logic [AGENTS_NUM-1:0]            arb_requests_o,
  input  logic [AGENTS_NUM-1:0]            arb_grants_i,
  output logic [AGENTS_NUM-1:0]            pop_o,
  output logic                             valid_o,
  output logic [FLIT_SIZE-1:0]             flit_o,
  input  logic                             credit_i,
  output logic                             credit_error_o
);

  localparam int OW = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state, state_n;
  logic [OW-1:0]  owner, owner_n;
  logic [CW-1:0]  credits;
  logic           can_send;
  logic           pop_any;
  logic [FLIT_SIZE-1:0] pop_flit;

  // Registered count only: a credit returned this cycle is usable next cycle.
  assign can_send = (credits != '0);
  assign pop_any  = |pop_o;

  always_comb begin
    state_n        = state;
    owner_n        = owner;
    arb_requests_o = '0;
    pop_o          = '0;
    // While in reset nothing is requested or consumed, so no flit is lost.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          arb_requests_o = requests_i & head_i & {AGENTS_NUM{can_send}};
          for (int i = 0; i < AGENTS_NUM; i++) begin
            if (arb_grants_i[i] && arb_requests_o[i]) begin
              pop_o    = '0;
              pop_o[i] = 1'b1;
              // A head&tail flit is a whole packet: no lock needed.
              if (!tail_i[i]) begin
                state_n = LOCKED;
                owner_n = OW'(i);
              end
            end
          end
        end
        LOCKED: begin
          // Requests stay low so the arbiter pointer is frozen mid-packet.
          if (requests_i[owner] && can_send) begin
            pop_o[owner] = 1'b1;
            if (tail_i[owner]) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    pop_flit = '0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      if (pop_o[i]) pop_flit = flits_i[i*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= '0;
      credits        <= CMAX;
      valid_o        <= 1'b0;
      flit_o         <= '0;
      credit_error_o <= 1'b0;
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      valid_o        <= pop_any;
      credit_error_o <= 1'b0;
      if (pop_any) flit_o <= pop_flit;
      case ({pop_any, credit_i})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CMAX) credit_error_o <= 1'b1;
          else                 credits <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_output_scheduler.sv
// Randomized bench for packet_output_scheduler with a packet-level reference
// model and an environment round-robin arbiter.
module tb_packet_output_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CM = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, head, tail, arbreq, gnt, pop;
  logic [N*W-1:0] flits;
  logic           valid, credit, cerr;
  logic [W-1:0]   flit;

  always #5 clk = ~clk;

  packet_output_scheduler #(
    .AGENTS_NUM(N), .FLIT_SIZE(W), .CREDIT_MAX(CM)
  ) dut (
    .clk(clk), .rst(rst),
    .requests_i(req), .head_i(head), .tail_i(tail), .flits_i(flits),
    .arb_requests_o(arbreq), .arb_grants_i(gnt), .pop_o(pop),
    .valid_o(valid), .flit_o(flit),
    .credit_i(credit), .credit_error_o(cerr)
  );

  // environment round-robin arbiter
  int ptr;
  int gidx;
  always_comb begin
    gnt  = '0;
    gidx = -1;
    for (int k = 0; k < N; k++) begin
      if (gidx < 0 && arbreq[(ptr + k) % N]) gidx = (ptr + k) % N;
    end
    if (gidx >= 0) gnt[gidx] = 1'b1;
  end
  always @(posedge clk) begin
    if (rst) ptr <= 0;
    else if (gidx >= 0) ptr <= (gidx + 1) % N;
  end

  // upstream agents: packet streams
  int         len [N];
  int         pos [N];
  logic [W-1:0] data [N];
  int         orphan [N];
  int         rp, cp;

  // reference model
  int         m_owner;
  int         m_cred;
  logic       m_valid, m_cerr;
  logic [W-1:0] m_flit;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_pkt(int a);
    len[a]    = $urandom_range(1, 4);
    pos[a]    = 0;
    data[a]   = W'($urandom);
    orphan[a] = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cred  = CM;
    m_valid = 1'b0;
    m_cerr  = 1'b0;
    m_flit  = '0;
  endtask

  task automatic step();
    int p;
    logic [N-1:0] ereq;
    @(negedge clk);
    rst    = ($urandom_range(0, 199) == 0);
    credit = ($urandom_range(0, 99) < cp);
    for (int a = 0; a < N; a++) begin
      req[a]  = (orphan[a] == 0 || pos[a] != 0) && ($urandom_range(0, 99) < rp);
      head[a] = (pos[a] == 0);
      tail[a] = (pos[a] == len[a] - 1);
      flits[a*W +: W] = data[a];
    end
    #1;
    chk("valid", 64'(valid), 64'(m_valid));
    chk("flit", 64'(flit), 64'(m_flit));
    chk("credit_err", 64'(cerr), 64'(m_cerr));
    chk("credits", 64'(dut.credits), 64'(m_cred));
    p    = -1;
    ereq = '0;
    if (!rst) begin
      if (m_owner < 0) begin
        for (int a = 0; a < N; a++) ereq[a] = req[a] & head[a] & (m_cred > 0);
        if (gidx >= 0 && ereq[gidx]) p = gidx;
      end else if (req[m_owner] && m_cred > 0) begin
        p = m_owner;
      end
    end
    chk("arb_req", 64'(arbreq), 64'(ereq));
    chk("pop", 64'(pop), (p >= 0) ? (64'd1 << p) : 64'd0);
    if (rst) begin
      model_reset();
      for (int a = 0; a < N; a++) if (pos[a] != 0) orphan[a] = 5;
    end else begin
      if (p >= 0) begin
        if (m_owner < 0) begin
          if (!tail[p]) m_owner = p;
        end else if (tail[p]) begin
          m_owner = -1;
        end
      end
      m_cerr = credit && p < 0 && m_cred == CM;
      m_cred = m_cred + (credit ? 1 : 0) - (p >= 0 ? 1 : 0);
      if (m_cred > CM) m_cred = CM;
      m_valid = (p >= 0);
      if (p >= 0) begin
        m_flit  = data[p];
        pos[p]  = pos[p] + 1;
        data[p] = W'($urandom);
        if (pos[p] == len[p]) new_pkt(p);
      end
    end
    // a body flit stranded by reset is never sent; upstream restarts it
    for (int a = 0; a < N; a++) begin
      if (orphan[a] > 0) begin
        orphan[a]--;
        if (orphan[a] == 0) new_pkt(a);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    head   = '0;
    tail   = '0;
    flits  = '0;
    credit = 1'b0;
    rp     = 80;
    cp     = 50;
    for (int a = 0; a < N; a++) new_pkt(a);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_flit", 64'(flit), 64'd0);
    chk("rst_cerr", 64'(cerr), 64'd0);
    chk("rst_credits", 64'(dut.credits), 64'(CM));
    chk("rst_arb_req", 64'(arbreq), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    for (int ph = 0; ph < 4; ph++) begin
      unique case (ph)
        0: begin rp = 80; cp = 50; end
        1: begin rp = 90; cp = 10; end
        2: begin rp = 40; cp = 90; end
        default: begin rp = 100; cp = 100; end
      endcase
      repeat (1000) step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
